// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor.
// Each clock adds the low DIGIT bits of the operand registers through a DIGIT-bit
// ripple of full-adder cells. The carry between digits is held in a register.
// A full operation takes N = WIDTH/DIGIT RUN cycles. The controlling FSM talks to
// this block through a start/busy/done handshake.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, accepted in IDLE or DONE
//   sub    - 0: a+b+c_in, 1: a-b-c_in (c_in is a borrow-in)
//   a, b   - WIDTH-bit operands, sampled on the accepting edge
//   c_in   - carry-in / borrow-in, sampled on the accepting edge
//   busy   - high while the operation is in RUN
//   done   - one-cycle pulse when sum/c_out/ovf have just been updated
//   sum    - WIDTH-bit result, held until the next completion
//   c_out  - carry out of the MSB (in sub mode, 1 = no borrow)
//   ovf    - signed overflow (carry into MSB xor carry out of MSB)
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  // a_r doubles as the result shift register: result digits enter at the top
  // while operand digits leave at the bottom. After N shifts it holds the sum.
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT:0]   chain_s;
  logic [DIGIT-1:0] dsum_s;
  logic [WIDTH-1:0] a_next_s;

  // Single full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Ripple of DIGIT full-adder cells over the current low digit.
  always_comb begin
    chain_s    = '0;
    dsum_s     = '0;
    chain_s[0] = carry_r;
    for (int i = 0; i < DIGIT; i++) begin
      {chain_s[i+1], dsum_s[i]} = full_add(a_r[i], b_r[i], chain_s[i]);
    end
  end

  // The new digit enters at the top and the consumed digit drops off the bottom.
  always_comb begin
    a_next_s = WIDTH'({dsum_s, a_r} >> DIGIT);
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + ~borrow; c_out then means "no borrow".
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? ~c_in : c_in;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_next_s;
          b_r     <= b_r >> DIGIT;
          carry_r <= chain_s[DIGIT];
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            // The outputs change only here, so partial results are never visible.
            sum     <= a_next_s;
            c_out   <= chain_s[DIGIT];
            ovf     <= chain_s[DIGIT-1] ^ chain_s[DIGIT];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            done    <= 1'b0;
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
